// File: rtl/axi_slave_responder.sv
// AXI4 responder backed by an internal word array.
// Write and read paths are independent FSMs sharing only the array.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting beats and writing enabled bytes
//   W_RESP | bvalid high with the worst beat response, waiting bready
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high, one beat per cycle while rready is high
module axi_slave_responder #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 42,
    parameter int ID_WIDTH   = 8,
    parameter int MEM_DEPTH  = 512
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [3:0]              awqos,
    input  logic                    awlock,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [3:0]              arqos,
    input  logic                    arlock,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic [31:0]             o_wr_done_count,
    output logic [31:0]             o_rd_done_count,
    output logic                    o_error_valid
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [2:0]            FULL_SIZE = 3'(SHIFT);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // response codes are ordered so that the numerically larger one is more severe
    function automatic logic [1:0] sev_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [7:0]            w_len, w_beat;
    logic                  w_bad;
    logic [1:0]            w_sev;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [7:0]            r_len, r_beat;
    logic                  r_bad, r_err;

    logic unused_ok;
    assign unused_ok = ^{awqos, awlock, arqos, arlock};

    logic [ADDR_WIDTH-1:0] w_idx;
    logic w_oor, w_hs, w_last_beat, mem_we;
    logic [1:0] w_beat_sev;

    assign w_idx       = w_base + ADDR_WIDTH'(w_beat);
    assign w_oor       = (w_idx >= DEPTH_A);
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_beat == w_len);
    assign w_beat_sev  = w_oor ? DECERR : ((wlast != w_last_beat) ? SLVERR : OKAY);
    assign mem_we      = w_hs && !w_bad && !w_oor;

    logic b_hs, r_done;
    assign b_hs   = bvalid && bready;
    assign r_done = rvalid && rready && rlast;

    // next read beat: beat 0 straight from the AR channel, later beats from the captured burst
    logic [ADDR_WIDTH-1:0] f_idx;
    logic                  f_bad, f_last;
    logic [1:0]            f_resp;
    logic [DATA_WIDTH-1:0] f_data;
    always_comb begin
        f_idx  = '0;
        f_bad  = 1'b0;
        f_last = 1'b0;
        if (r_state == R_IDLE) begin
            f_idx  = araddr >> SHIFT;
            f_bad  = (arburst != 2'b01) || (arsize != FULL_SIZE);
            f_last = (arlen == 8'd0);
        end else begin
            f_idx  = r_base + ADDR_WIDTH'(r_beat) + ADDR_WIDTH'(1);
            f_bad  = r_bad;
            f_last = ((r_beat + 8'd1) == r_len);
        end
        f_resp = (f_idx >= DEPTH_A) ? DECERR : (f_bad ? SLVERR : OKAY);
        f_data = (f_resp == OKAY) ? mem[f_idx[IDX_W-1:0]] : '0;
    end

    // byte-enabled array write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_idx[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // write FSM: address capture, beat acceptance, worst-case response
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            bid     <= '0;
            w_base  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_bad   <= 1'b0;
            w_sev   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= awid;
                        w_base  <= awaddr >> SHIFT;
                        w_len   <= awlen;
                        w_beat  <= '0;
                        w_bad   <= (awburst != 2'b01) || (awsize != FULL_SIZE);
                        w_sev   <= ((awburst != 2'b01) || (awsize != FULL_SIZE)) ? SLVERR : OKAY;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_sev <= sev_max(w_sev, w_beat_sev);
                        if (w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= sev_max(w_sev, w_beat_sev);
                            w_state <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // read FSM: registered beat fetch, holds while rready is low
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rid     <= '0;
            rresp   <= OKAY;
            rlast   <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_bad   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rdata   <= f_data;
                        rresp   <= f_resp;
                        rlast   <= f_last;
                        rid     <= arid;
                        r_base  <= araddr >> SHIFT;
                        r_len   <= arlen;
                        r_beat  <= '0;
                        r_bad   <= f_bad;
                        r_err   <= (f_resp != OKAY);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                            rdata  <= f_data;
                            rresp  <= f_resp;
                            rlast  <= f_last;
                            r_err  <= r_err || (f_resp != OKAY);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // completion counters and a single merged error pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_done_count <= '0;
            o_rd_done_count <= '0;
            o_error_valid   <= 1'b0;
        end else begin
            if (b_hs && (o_wr_done_count != 32'hFFFF_FFFF)) o_wr_done_count <= o_wr_done_count + 32'd1;
            if (r_done && (o_rd_done_count != 32'hFFFF_FFFF)) o_rd_done_count <= o_rd_done_count + 32'd1;
            o_error_valid <= (b_hs && (bresp != OKAY)) || (r_done && r_err);
        end
    end

endmodule
